// File: rtl/char_out_uart.sv
// Character sink for the core's output strobe: a small byte FIFO that never
// back-pressures the writer, drained by an 8N1 UART transmitter on tx.
module char_out_uart #(
    parameter int CLK_PER_BIT = 16,
    parameter int FIFO_LOG2   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sendingChar,
    input  logic [7:0]           sendedChar,
    output logic                 tx,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_LOG2:0]   fifo_count
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CW    = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0]        CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);
    localparam logic [FIFO_LOG2:0]   Q_ONE    = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2:0]   Q_FULL   = {1'b1, {FIFO_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q;
    logic [CW-1:0]        bit_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           shift_q;
    logic                 tx_q;
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic                 ovf_q;
    logic                 bit_end, has_data, full, pop, push;

    assign bit_end  = (bit_cnt_q == CNT_LAST);
    assign has_data = (count_q != '0);
    assign full     = (count_q == Q_FULL);
    // Pop decisions use the registered count, so a byte written this cycle
    // is only seen by the transmitter on the next one.
    assign pop      = has_data && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    assign push     = sendingChar && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + Q_ONE;
        else if (pop && !push)
            count_d = count_q - Q_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset && push)
            mem_q[wr_ptr_q] <= sendedChar;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            if (sendingChar && !push)
                ovf_q <= 1'b1;
        end
    end

    // tx_q is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= START;
                        tx_q      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (pop) begin
                            shift_q   <= mem_q[rd_ptr_q];
                            bit_idx_q <= '0;
                            state_q   <= START;
                            tx_q      <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || has_data;
endmodule

// File: tb/tb_char_out_uart.sv
// Bench for char_out_uart: reset/first-frame vector table, directed corner
// sequences, and random strobes against a queue-of-bits line model.
module tb_char_out_uart;
    localparam int CPB   = 4;
    localparam int LOG2  = 3;
    localparam int DEPTH = 1 << LOG2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sendingChar = 1'b0;
    logic [7:0]    sendedChar = 8'h00;
    logic          tx, busy, overflow;
    logic [LOG2:0] fifo_count;

    char_out_uart #(.CLK_PER_BIT(CPB), .FIFO_LOG2(LOG2)) dut (
        .clk(clk), .reset(reset), .sendingChar(sendingChar), .sendedChar(sendedChar),
        .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: bytes waiting, plus the exact line levels still to be shown for
    // the frame in flight (head = level currently on tx).
    logic [7:0] mq[$];
    bit         stream[$];
    bit         m_ovf;

    logic [7:0] rx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input logic [7:0] d);
        int  pre;
        bit  popped;
        logic [7:0] b;
        if (!r) begin
            mq.delete();
            stream.delete();
            m_ovf = 0;
            return;
        end
        pre = mq.size();
        popped = 0;
        if (stream.size() != 0) void'(stream.pop_front());
        if (stream.size() == 0 && pre > 0) begin
            b = mq.pop_front();
            popped = 1;
            for (int k = 0; k < CPB; k++) stream.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < CPB; k++) stream.push_back(b[i]);
            for (int k = 0; k < CPB; k++) stream.push_back(1'b1);
        end
        if (s) begin
            if (pre < DEPTH || popped) mq.push_back(d);
            else m_ovf = 1;
        end
    endtask

    function automatic bit m_busy();
        return (stream.size() != 0) || (mq.size() != 0);
    endfunction

    task automatic check_model();
        chk("tx", {31'd0, tx}, {31'd0, (stream.size() != 0) ? stream[0] : 1'b1});
        chk("busy", {31'd0, busy}, {31'd0, m_busy()});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("fifo_count", {28'd0, fifo_count}, mq.size());
    endtask

    task automatic step(input bit r, input bit s, input logic [7:0] d);
        reset = r;
        sendingChar = s;
        sendedChar = d;
        @(posedge clk);
        model_edge(r, s, d);
        #1;
    endtask

    task automatic stepc(input bit r, input bit s, input logic [7:0] d);
        step(r, s, d);
        check_model();
    endtask

    task automatic drain(input int maxc);
        int i = 0;
        while (m_busy() && i < maxc) begin
            stepc(1, 0, 8'h00);
            i++;
        end
        if (m_busy()) chk("drain_timeout", 1, 0);
    endtask

    task automatic wait_stream(input int sz, input int maxc);
        int i = 0;
        while (stream.size() != sz && i < maxc) begin
            stepc(1, 0, 8'h00);
            i++;
        end
        if (stream.size() != sz) chk("wait_timeout", stream.size(), sz);
    endtask

    // Independent UART receiver sampling mid-bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(posedge clk);
            #1;
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    b[i] = tx;
                end
                repeat (CPB) @(posedge clk);
                #1;
                if (tx == 1'b1) rx.push_back(b);
            end
        end
    end

    typedef struct {
        bit         rst_n;
        bit         stb;
        logic [7:0] d;
        int         cnt;
        bit         ovf;
        bit         txv;
        bit         bsy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0] want[$];
        bit r, s;
        tbl[0]  = '{0, 0, 8'h00, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 8'h77, 0, 0, 1, 0};
        tbl[2]  = '{1, 1, 8'h41, 1, 0, 1, 1};
        tbl[3]  = '{1, 0, 8'h00, 0, 0, 0, 1};
        tbl[4]  = '{1, 0, 8'h00, 0, 0, 0, 1};
        tbl[5]  = '{1, 0, 8'h00, 0, 0, 0, 1};
        tbl[6]  = '{1, 0, 8'h00, 0, 0, 0, 1};
        tbl[7]  = '{1, 0, 8'h00, 0, 0, 1, 1};
        tbl[8]  = '{1, 0, 8'h00, 0, 0, 1, 1};
        tbl[9]  = '{1, 0, 8'h00, 0, 0, 1, 1};
        tbl[10] = '{1, 0, 8'h00, 0, 0, 1, 1};
        tbl[11] = '{1, 0, 8'h00, 0, 0, 0, 1};

        // Reset and first frame of 0x41
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst_n, tbl[i].stb, tbl[i].d);
            chk($sformatf("vec%0d.count", i), {28'd0, fifo_count}, tbl[i].cnt);
            chk($sformatf("vec%0d.overflow", i), {31'd0, overflow}, {31'd0, tbl[i].ovf});
            chk($sformatf("vec%0d.tx", i), {31'd0, tx}, {31'd0, tbl[i].txv});
            chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            check_model();
        end
        drain(200);
        chk("single.busy_end", {31'd0, busy}, 0);
        chk("single.rx_n", rx.size(), 1);
        if (rx.size() == 1) chk("single.rx0", rx[0], 8'h41);

        // Back-to-back frames
        rx.delete();
        stepc(1, 1, 8'h48);
        chk("b2b.cnt0", {28'd0, fifo_count}, 1);
        stepc(1, 1, 8'h69);
        chk("b2b.cnt1", {28'd0, fifo_count}, 1);
        stepc(1, 1, 8'h0A);
        chk("b2b.cnt2", {28'd0, fifo_count}, 2);
        while (m_busy()) begin
            stepc(1, 0, 8'h00);
            if (m_busy()) chk("b2b.busy", {31'd0, busy}, 1);
            if (n_cmp > 90000) break;
        end
        want = '{8'h48, 8'h69, 8'h0A};
        chk("b2b.rx_n", rx.size(), 3);
        foreach (want[i]) if (i < rx.size()) chk($sformatf("b2b.rx%0d", i), rx[i], want[i]);

        // Overflow: ten strobes into a depth-8 queue
        rx.delete();
        for (int i = 0; i < 10; i++) begin
            stepc(1, 1, 8'h30 + 8'(i));
            if (i == 8) chk("ovf.cnt_full", {28'd0, fifo_count}, 8);
            if (i == 8) chk("ovf.not_yet", {31'd0, overflow}, 0);
        end
        chk("ovf.set", {31'd0, overflow}, 1);
        drain(1000);
        chk("ovf.sticky", {31'd0, overflow}, 1);
        chk("ovf.rx_n", rx.size(), 9);
        for (int i = 0; i < 9; i++) if (i < rx.size()) chk($sformatf("ovf.rx%0d", i), rx[i], 8'h30 + 8'(i));

        // Full queue, strobe on the last STOP cycle
        stepc(0, 0, 8'h00);
        for (int i = 0; i < 9; i++) stepc(1, 1, 8'hC0 + 8'(i));
        chk("fullpop.cnt_pre", {28'd0, fifo_count}, 8);
        wait_stream(1, 100);
        stepc(1, 1, 8'hEE);
        chk("fullpop.cnt", {28'd0, fifo_count}, 8);
        chk("fullpop.ovf", {31'd0, overflow}, 0);

        // Reset during DATA bit 3 of 0x55 with two bytes queued
        stepc(0, 0, 8'h00);
        stepc(1, 1, 8'h55);
        stepc(1, 1, 8'hAA);
        stepc(1, 1, 8'hBB);
        chk("rst.queued", {28'd0, fifo_count}, 2);
        wait_stream(22, 100);
        step(0, 0, 8'h00);
        chk("rst.tx", {31'd0, tx}, 1);
        chk("rst.busy", {31'd0, busy}, 0);
        chk("rst.cnt", {28'd0, fifo_count}, 0);
        chk("rst.ovf", {31'd0, overflow}, 0);
        for (int i = 0; i < 60; i++) stepc(1, 0, 8'h00);
        rx.delete();
        stepc(1, 1, 8'h20);
        drain(200);
        chk("rst.rx_n", rx.size(), 1);
        if (rx.size() == 1) chk("rst.rx0", rx[0], 8'h20);

        // Random bursts and gaps with rare resets
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 499) != 0);
            if (((c / 64) % 2) == 0) s = ($urandom_range(0, 1) == 1);
            else s = ($urandom_range(0, 59) == 0);
            stepc(r, s, 8'($urandom));
        end
        drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
